// File: rtl/ascon_aead_seq.sv
// ---------------------------------------------------------------------------
// ascon_aead_seq
//   Control sequencer for an ASCON-128/128a AEAD datapath. Walks through
//   initialisation, associated-data absorption, domain separation, message
//   encrypt/decrypt, finalisation and tag check. Only control strobes are
//   produced; the round engine, state register and data buffer live elsewhere.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           begin an operation (sampled only in IDLE)
//   mode            0 = encrypt, 1 = decrypt (latched at start)
//   ad_blocks       padded AD block count, 0 skips the AD phase
//   msg_blocks      padded message block count, 0 is treated as 1
//   blk_valid       data buffer presents the next rate block
//   blk_ready       sequencer accepts a block this cycle (WAIT states)
//   absorb_ad       strobe: XOR AD block into rate
//   absorb_msg      strobe: encrypt/decrypt message block in rate
//   round_start     pulse: launch a permutation
//   total_rounds    round count of the current/pending permutation
//   round_done      pulse from round engine: permutation complete
//   key_xor_init    strobe: XOR 0*||K into capacity after init
//   dom_sep         strobe: XOR 1 into state LSB
//   key_xor_fin     strobe: XOR K into capacity before finalisation
//   tag_match       tag comparator result, valid in TAG
//   busy            high in every state except IDLE
//   phase           current state encoding
//   done            one-cycle completion pulse
//   auth_fail       decrypt tag mismatch, held until the next start
// ---------------------------------------------------------------------------
module ascon_aead_seq #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] ad_blocks,
  input  logic [LEN_W-1:0] msg_blocks,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             absorb_ad,
  output logic             absorb_msg,
  output logic             round_start,
  output logic [3:0]       total_rounds,
  input  logic             round_done,
  output logic             key_xor_init,
  output logic             dom_sep,
  output logic             key_xor_fin,
  input  logic             tag_match,
  output logic             busy,
  output logic [3:0]       phase,
  output logic             done,
  output logic             auth_fail
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_INIT_KEY = 4'd2,
    S_AD_WAIT  = 4'd3,
    S_AD_PERM  = 4'd4,
    S_DSEP     = 4'd5,
    S_MSG_WAIT = 4'd6,
    S_MSG_PERM = 4'd7,
    S_FIN_KEY  = 4'd8,
    S_FINAL    = 4'd9,
    S_TAG      = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  localparam logic [3:0]       L_PA  = 4'(PA_ROUNDS);
  localparam logic [3:0]       L_PB  = 4'(PB_ROUNDS);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_enter;
  logic             r_mode;
  logic [LEN_W-1:0] r_ad_cnt;
  logic [LEN_W-1:0] r_msg_cnt;
  logic             r_blk_ready;
  logic             r_round_start;
  logic [3:0]       r_total_rounds;
  logic             r_key_xor_init;
  logic             r_dom_sep;
  logic             r_key_xor_fin;
  logic             r_busy;
  logic             r_done;
  logic             r_auth_fail;

  function automatic logic is_perm(input state_t s);
    return (s == S_INIT) || (s == S_AD_PERM) || (s == S_MSG_PERM) || (s == S_FINAL);
  endfunction

  // Next-state decode; exits from the count-down phases use the pre-decrement value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_INIT;
        else       w_state_nxt = S_IDLE;
      end
      S_INIT: begin
        if (round_done) w_state_nxt = S_INIT_KEY;
        else            w_state_nxt = S_INIT;
      end
      S_INIT_KEY: begin
        if (r_ad_cnt != '0) w_state_nxt = S_AD_WAIT;
        else                w_state_nxt = S_DSEP;
      end
      S_AD_WAIT: begin
        if (blk_valid) w_state_nxt = S_AD_PERM;
        else           w_state_nxt = S_AD_WAIT;
      end
      S_AD_PERM: begin
        if (!round_done)         w_state_nxt = S_AD_PERM;
        else if (r_ad_cnt != '0) w_state_nxt = S_AD_WAIT;
        else                     w_state_nxt = S_DSEP;
      end
      S_DSEP: w_state_nxt = S_MSG_WAIT;
      S_MSG_WAIT: begin
        // The final message block goes straight to finalisation with no PB permutation.
        if (!blk_valid)              w_state_nxt = S_MSG_WAIT;
        else if (r_msg_cnt == L_ONE) w_state_nxt = S_FIN_KEY;
        else                         w_state_nxt = S_MSG_PERM;
      end
      S_MSG_PERM: begin
        if (round_done) w_state_nxt = S_MSG_WAIT;
        else            w_state_nxt = S_MSG_PERM;
      end
      S_FIN_KEY: w_state_nxt = S_FINAL;
      S_FINAL: begin
        if (round_done) w_state_nxt = S_TAG;
        else            w_state_nxt = S_FINAL;
      end
      S_TAG:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter = (w_state_nxt != r_state);

  // State, counters and registered strobes; each strobe is decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mode         <= 1'b0;
      r_ad_cnt       <= '0;
      r_msg_cnt      <= '0;
      r_blk_ready    <= 1'b0;
      r_round_start  <= 1'b0;
      r_total_rounds <= 4'd0;
      r_key_xor_init <= 1'b0;
      r_dom_sep      <= 1'b0;
      r_key_xor_fin  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_auth_fail    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_blk_ready    <= (w_state_nxt == S_AD_WAIT) || (w_state_nxt == S_MSG_WAIT);
      r_round_start  <= w_enter && is_perm(w_state_nxt);
      r_key_xor_init <= (w_state_nxt == S_INIT_KEY);
      r_dom_sep      <= (w_state_nxt == S_DSEP);
      r_key_xor_fin  <= (w_state_nxt == S_FIN_KEY);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_DONE);

      // Round count is loaded on entry and held for the whole permutation state.
      if (w_enter && ((w_state_nxt == S_INIT) || (w_state_nxt == S_FINAL))) begin
        r_total_rounds <= L_PA;
      end else if (w_enter && ((w_state_nxt == S_AD_PERM) || (w_state_nxt == S_MSG_PERM))) begin
        r_total_rounds <= L_PB;
      end else begin
        r_total_rounds <= r_total_rounds;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_ad_cnt    <= ad_blocks;
            r_msg_cnt   <= (msg_blocks == '0) ? L_ONE : msg_blocks;
            r_auth_fail <= 1'b0;
          end
        end
        S_AD_WAIT: begin
          if (blk_valid) r_ad_cnt <= r_ad_cnt - L_ONE;
        end
        S_MSG_WAIT: begin
          if (blk_valid) r_msg_cnt <= r_msg_cnt - L_ONE;
        end
        S_TAG: begin
          // Encrypt never reports an authentication failure.
          r_auth_fail <= r_mode & ~tag_match;
        end
        default: begin
          r_ad_cnt <= r_ad_cnt;
        end
      endcase
    end
  end

  // Absorb strobes coincide with the accepted handshake, so they follow blk_valid directly.
  assign absorb_ad    = (r_state == S_AD_WAIT)  & blk_valid;
  assign absorb_msg   = (r_state == S_MSG_WAIT) & blk_valid;
  assign blk_ready    = r_blk_ready;
  assign round_start  = r_round_start;
  assign total_rounds = r_total_rounds;
  assign key_xor_init = r_key_xor_init;
  assign dom_sep      = r_dom_sep;
  assign key_xor_fin  = r_key_xor_fin;
  assign busy         = r_busy;
  assign phase        = r_state;
  assign done         = r_done;
  assign auth_fail    = r_auth_fail;

endmodule

// File: tb/tb_ascon_aead_seq.sv
// ---------------------------------------------------------------------------
// tb_ascon_aead_seq
//   Self-checking bench for ascon_aead_seq. A behavioural round engine and data
//   buffer drive the handshakes; each operation's phase trace, strobes, round
//   counts, latency and auth_fail are compared with a model built from the
//   state list of the sequencer.
// ---------------------------------------------------------------------------
module tb_ascon_aead_seq;
  localparam int PA = 12;
  localparam int PB = 6;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [LW-1:0] ad_blocks;
  logic [LW-1:0] msg_blocks;
  logic          blk_valid;
  logic          blk_ready;
  logic          absorb_ad;
  logic          absorb_msg;
  logic          round_start;
  logic [3:0]    total_rounds;
  logic          round_done;
  logic          key_xor_init;
  logic          dom_sep;
  logic          key_xor_fin;
  logic          tag_match;
  logic          busy;
  logic [3:0]    phase;
  logic          done;
  logic          auth_fail;

  int n_checks = 0;
  int n_pass   = 0;

  int eng_lat  = 2;
  bit spur_en  = 1'b0;
  bit stall_en = 1'b0;
  bit hold_en  = 1'b0;
  logic last_af = 1'b0;

  ascon_aead_seq #(.PA_ROUNDS(PA), .PB_ROUNDS(PB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .ad_blocks(ad_blocks), .msg_blocks(msg_blocks),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .absorb_ad(absorb_ad), .absorb_msg(absorb_msg),
    .round_start(round_start), .total_rounds(total_rounds), .round_done(round_done),
    .key_xor_init(key_xor_init), .dom_sep(dom_sep), .key_xor_fin(key_xor_fin),
    .tag_match(tag_match), .busy(busy), .phase(phase), .done(done), .auth_fail(auth_fail)
  );

  always #5 clk = ~clk;

  // Round engine model: round_done eng_lat cycles after round_start (0 = same cycle);
  // optionally fires spurious round_done pulses while the sequencer waits for AD.
  initial begin
    int  cnt;
    bit  eng_busy;
    round_done = 1'b0;
    cnt = 0;
    eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      round_done = 1'b0;
      if (rst) begin
        eng_busy = 1'b0;
      end else begin
        if (round_start) begin
          eng_busy = 1'b1;
          cnt = eng_lat;
        end
        if (eng_busy) begin
          if (cnt == 0) begin
            round_done = 1'b1;
            eng_busy = 1'b0;
          end else begin
            cnt--;
          end
        end else if (spur_en && phase == 4'd3) begin
          round_done = 1'b1;
        end
      end
    end
  end

  // Data buffer model: valid always, randomly stalling, or held low for the
  // first 5 AD_WAIT cycles of an operation.
  initial begin
    int h;
    blk_valid = 1'b0;
    h = 0;
    forever begin
      @(negedge clk);
      if (!hold_en) h = 0;
      if (hold_en && phase == 4'd3 && h < 5) begin
        blk_valid = 1'b0;
        h++;
      end else if (stall_en) begin
        blk_valid = 1'($urandom_range(0, 1));
      end else begin
        blk_valid = 1'b1;
      end
    end
  end

  task automatic run_op(input string name, input bit op_mode, input int a, input int m,
                        input int lat, input bit stall, input bit hold, input bit spur,
                        input bit noise, input bit tag, output int n_adp, output int n_msgp);
    int obs[$];
    int expq[$];
    int rs[$];
    int exp_rs[$];
    int mm, cyc, busy_cyc, n_ad, n_msg, n_done, rule_err, exp_lat, diff;
    logic [3:0] ph, prev;
    bit   fin, perm;
    logic exp_af, af_first, af_done;

    mm = (m == 0) ? 1 : m;
    exp_af = op_mode & ~tag;
    eng_lat = lat; stall_en = stall; hold_en = hold; spur_en = spur;
    n_adp = 0; n_msgp = 0; n_ad = 0; n_msg = 0; n_done = 0; rule_err = 0;
    busy_cyc = 0; cyc = 0; fin = 1'b0; af_done = 1'bx; af_first = 1'bx;

    @(negedge clk);
    tag_match = tag;
    #2;
    n_checks++;
    if (auth_fail !== last_af) $display("FAIL %s/af_held_idle: got %b expected %b", name, auth_fail, last_af);
    else n_pass++;

    @(negedge clk);
    start = 1'b1; mode = op_mode; ad_blocks = LW'(a); msg_blocks = LW'(m);
    #2;
    prev = phase;
    obs.push_back(int'(phase));

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && cyc == 4) begin
        start = 1'b1; mode = ~op_mode; ad_blocks = LW'(a + 3); msg_blocks = LW'(m + 5);
      end
      #2;
      ph = phase;
      if (cyc == 0) af_first = auth_fail;
      if (ph != prev) begin
        obs.push_back(int'(ph));
        if (ph == 4'd4) n_adp++;
        if (ph == 4'd7) n_msgp++;
      end
      perm = (ph == 4'd1) || (ph == 4'd4) || (ph == 4'd7) || (ph == 4'd9);
      if (blk_ready    !== (ph == 4'd3 || ph == 4'd6))      rule_err++;
      if (absorb_ad    !== (ph == 4'd3 && blk_valid))       rule_err++;
      if (absorb_msg   !== (ph == 4'd6 && blk_valid))       rule_err++;
      if (round_start  !== (perm && ph != prev))            rule_err++;
      if (perm && total_rounds !== ((ph == 4'd1 || ph == 4'd9) ? 4'(PA) : 4'(PB))) rule_err++;
      if (key_xor_init !== (ph == 4'd2))                    rule_err++;
      if (dom_sep      !== (ph == 4'd5))                    rule_err++;
      if (key_xor_fin  !== (ph == 4'd8))                    rule_err++;
      if (done         !== (ph == 4'd11))                   rule_err++;
      if (busy         !== (ph != 4'd0))                    rule_err++;
      if (round_start === 1'b1) rs.push_back(int'(total_rounds));
      if (absorb_ad === 1'b1)  n_ad++;
      if (absorb_msg === 1'b1) n_msg++;
      if (done === 1'b1) begin n_done++; af_done = auth_fail; end
      if (busy === 1'b1) busy_cyc++;
      if (ph == 4'd0) fin = 1'b1;
      prev = ph;
      cyc++;
    end
    hold_en = 1'b0; spur_en = 1'b0; stall_en = 1'b0;

    // Reference model: state visit list and permutation schedule.
    expq = '{0, 1, 2};
    for (int i = 0; i < a; i++) begin expq.push_back(3); expq.push_back(4); end
    expq.push_back(5);
    for (int i = 0; i < mm - 1; i++) begin expq.push_back(6); expq.push_back(7); end
    expq.push_back(6); expq.push_back(8); expq.push_back(9);
    expq.push_back(10); expq.push_back(11); expq.push_back(0);
    exp_rs.push_back(PA);
    for (int i = 0; i < a + mm - 1; i++) exp_rs.push_back(PB);
    exp_rs.push_back(PA);
    exp_lat = (lat + 1) + 1 + a * (lat + 2) + 1 + mm + (mm - 1) * (lat + 1) + 1 + (lat + 1) + 1 + 1;
    if (hold && a > 0) exp_lat += 5;

    n_checks++;
    if (!fin) $display("FAIL %s/timeout: got no return to IDLE after %0d cycles expected completion", name, cyc);
    else n_pass++;

    n_checks++;
    if (af_first !== 1'b0) $display("FAIL %s/af_clear_on_start: got %b expected 0", name, af_first);
    else n_pass++;

    diff = -1;
    for (int i = 0; i < expq.size(); i++) begin
      if (diff < 0 && (i >= obs.size() || obs[i] != expq[i])) diff = i;
    end
    if (diff < 0 && obs.size() != expq.size()) diff = expq.size();
    n_checks++;
    if (diff >= 0)
      $display("FAIL %s/phase_seq: got %0d states (first diff at %0d) expected %p", name, obs.size(), diff, expq);
    else n_pass++;

    n_checks++;
    if (rs != exp_rs) $display("FAIL %s/round_sched: got %p expected %p", name, rs, exp_rs);
    else n_pass++;

    n_checks++;
    if (rule_err !== 0) $display("FAIL %s/strobe_rules: got %0d violations expected 0", name, rule_err);
    else n_pass++;

    n_checks++;
    if (n_ad !== a || n_msg !== mm)
      $display("FAIL %s/absorb_cnt: got ad=%0d msg=%0d expected ad=%0d msg=%0d", name, n_ad, n_msg, a, mm);
    else n_pass++;

    n_checks++;
    if (n_done !== 1) $display("FAIL %s/done_cnt: got %0d expected 1", name, n_done);
    else n_pass++;

    n_checks++;
    if (af_done !== exp_af) $display("FAIL %s/af_at_done: got %b expected %b", name, af_done, exp_af);
    else n_pass++;

    if (!stall) begin
      n_checks++;
      if (busy_cyc !== exp_lat) $display("FAIL %s/latency: got %0d expected %0d", name, busy_cyc, exp_lat);
      else n_pass++;
    end

    @(negedge clk);
    #2;
    n_checks++;
    if (auth_fail !== exp_af || phase !== 4'd0)
      $display("FAIL %s/af_after: got af=%b phase=%0d expected af=%b phase=0", name, auth_fail, phase, exp_af);
    else n_pass++;
    last_af = exp_af;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; ad_blocks = '0; msg_blocks = '0; tag_match = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({phase, busy, blk_ready, round_start, total_rounds, done, auth_fail,
         key_xor_init, dom_sep, key_xor_fin, absorb_ad, absorb_msg} !== 19'd0)
      $display("FAIL reset/outputs: got phase=%0d busy=%b rounds=%0d af=%b expected all 0",
               phase, busy, total_rounds, auth_fail);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    last_af = 1'b0;
  endtask

  task automatic test_basic();
    int adp, msgp;
    run_op("basic_enc", 1'b0, 1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, adp, msgp);
    n_checks++;
    if (msgp !== 0) $display("FAIL basic_enc/no_last_perm: got %0d MSG_PERM expected 0", msgp);
    else n_pass++;
  endtask

  task automatic test_no_ad();
    int adp, msgp;
    run_op("no_ad", 1'b0, 0, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, adp, msgp);
    n_checks++;
    if (msgp !== 2 || adp !== 0) $display("FAIL no_ad/perm_cnt: got msg_perm=%0d ad_perm=%0d expected 2 and 0", msgp, adp);
    else n_pass++;
  endtask

  task automatic test_ad_stall_spurious();
    int adp, msgp;
    run_op("ad_stall", 1'b0, 2, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, adp, msgp);
    n_checks++;
    if (adp !== 2) $display("FAIL ad_stall/ad_perm_cnt: got %0d expected 2", adp);
    else n_pass++;
  endtask

  task automatic test_decrypt();
    int adp, msgp;
    run_op("dec_fail", 1'b1, 1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, adp, msgp);
    run_op("dec_ok",   1'b1, 0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, adp, msgp);
    run_op("dec_fail2", 1'b1, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, adp, msgp);
    run_op("enc_tag0", 1'b0, 1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, adp, msgp);
  endtask

  task automatic test_midop_noise();
    int adp, msgp;
    run_op("midop_noise", 1'b1, 2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, adp, msgp);
    n_checks++;
    if (adp !== 2 || msgp !== 1) $display("FAIL midop_noise/perm_cnt: got ad=%0d msg=%0d expected 2 and 1", adp, msgp);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    int adp, msgp;
    run_op("msg_zero", 1'b0, 1, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, adp, msgp);
    run_op("lat_zero", 1'b1, 2, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, adp, msgp);
  endtask

  task automatic test_reset_mid();
    int adp, msgp, n_done, bad;
    bit seen;
    eng_lat = 6;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; ad_blocks = LW'(0); msg_blocks = LW'(3); tag_match = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0; n_done = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (done === 1'b1) n_done++;
      if (phase == 4'd7) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL reset_mid/reach_msg_perm: got phase=%0d expected 7", phase);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({phase, busy, blk_ready, round_start, total_rounds, done, auth_fail,
         key_xor_init, dom_sep, key_xor_fin, absorb_ad, absorb_msg} !== 19'd0)
      $display("FAIL reset_mid/async_outputs: got phase=%0d busy=%b rounds=%0d expected all 0",
               phase, busy, total_rounds);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      #2;
      if (done === 1'b1) n_done++;
      if (phase !== 4'd0) bad++;
    end
    n_checks++;
    if (n_done !== 0 || bad !== 0) $display("FAIL reset_mid/no_done: got done=%0d non_idle=%0d expected 0 and 0", n_done, bad);
    else n_pass++;
    last_af = 1'b0;
    run_op("after_reset", 1'b0, 1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, adp, msgp);
  endtask

  task automatic test_random();
    int adp, msgp, a, m, mm;
    bit md, tg, st;
    for (int k = 0; k < 12; k++) begin
      a  = int'($urandom_range(0, 3));
      m  = int'($urandom_range(0, 4));
      md = 1'($urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      mm = (m == 0) ? 1 : m;
      run_op($sformatf("rand%0d", k), md, a, m, int'($urandom_range(0, 4)), st,
             1'b0, 1'b0, 1'b0, tg, adp, msgp);
      n_checks++;
      if (adp !== a || msgp !== mm - 1)
        $display("FAIL rand%0d/perm_cnt: got ad=%0d msg=%0d expected %0d and %0d", k, adp, msgp, a, mm - 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_ad();
    test_ad_stall_spurious();
    test_decrypt();
    test_midop_noise();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascon_aead_seq.md
Name: ascon_aead_seq

Overview:
Parametrised AEAD sequencer for the ASCON-128/128a datapath. It sequences initialisation, associated-data (AD) absorption, domain separation, message encrypt/decrypt, finalisation and tag check. It runs a block-level valid/ready handshake toward the data buffer and a pulse start/done handshake toward the permutation round engine. The round engine, state register and data buffer are separate blocks; this block drives only their control strobes.

Parameters:
PA_ROUNDS, 12, rounds for initialisation and finalisation permutations (1..15)
PB_ROUNDS, 6, rounds for inter-block permutations (6 for ASCON-128, 8 for ASCON-128a; 1..15)
LEN_W, 8, width of the AD and message block-count inputs

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = encrypt, 1 = decrypt; latched at start
ad_blocks  in  LEN_W  number of padded AD blocks; latched at start; 0 skips AD phase
msg_blocks  in  LEN_W  number of padded message blocks, including the final padded block; latched at start; 0 treated as 1
blk_valid  in  1  data buffer has the next rate block
blk_ready  out  1  sequencer accepts a block this cycle
absorb_ad  out  1  one-cycle strobe: XOR AD block into rate
absorb_msg  out  1  one-cycle strobe: encrypt/decrypt the message block in rate
round_start  out  1  one-cycle pulse that launches a permutation
total_rounds  out  4  round count for the current or pending permutation
round_done  in  1  one-cycle pulse from the round engine when the permutation completes
key_xor_init  out  1  one-cycle strobe: XOR 0^*||K into capacity after initialisation
dom_sep  out  1  one-cycle strobe: XOR 1 into the state LSB
key_xor_fin  out  1  one-cycle strobe: XOR K into capacity before finalisation
tag_match  in  1  comparator result, valid in the TAG state
busy  out  1  high in every state except IDLE
phase  out  4  current state encoding
done  out  1  one-cycle completion pulse
auth_fail  out  1  held result: decrypt tag mismatch; valid from done until the next start

Behaviour:
- Reset values: state IDLE, all strobes/pulses 0, busy 0, total_rounds 0, auth_fail 0, counters 0, latched mode 0.
- Reset mid-operation aborts immediately to IDLE. No done is issued.
- State encodings: IDLE=0, INIT=1, INIT_KEY=2, AD_WAIT=3, AD_PERM=4, DSEP=5, MSG_WAIT=6, MSG_PERM=7, FIN_KEY=8, FINAL=9, TAG=10, DONE=11.
- Permutation states INIT, AD_PERM, MSG_PERM, FINAL:
  - round_start pulses for exactly one cycle, the first cycle in the state.
  - The state waits for round_done.
  - total_rounds is PA_ROUNDS in INIT/FINAL and PB_ROUNDS in AD_PERM/MSG_PERM, held for the whole state.
  - round_done in any non-permutation state is ignored.
  - round_done in the same cycle as round_start is legal and exits the state after one cycle.
- IDLE: on start, latch mode and counters, then go to INIT. auth_fail clears to 0 on start.
- INIT -> INIT_KEY on round_done.
- INIT_KEY: key_xor_init for one cycle. Next state is AD_WAIT if ad_cnt != 0, else DSEP.
- AD_WAIT:
  - blk_ready = 1.
  - On blk_valid: absorb_ad = 1 in the same cycle, ad_cnt decrements, go to AD_PERM.
- AD_PERM -> on round_done: AD_WAIT if ad_cnt != 0, else DSEP.
- DSEP: dom_sep for one cycle, then MSG_WAIT. DSEP is entered even when ad_blocks = 0.
- MSG_WAIT:
  - blk_ready = 1.
  - On blk_valid: absorb_msg = 1, msg_cnt decrements.
  - If this was the last block (msg_cnt was 1), go to FIN_KEY. Otherwise go to MSG_PERM.
  - The last message block is never followed by a PB permutation.
- MSG_PERM -> MSG_WAIT on round_done.
- FIN_KEY: key_xor_fin for one cycle, then FINAL.
- FINAL -> TAG on round_done.
- TAG: one cycle. If latched mode = 1, auth_fail <= ~tag_match; if mode = 0, auth_fail <= 0. Then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- blk_ready is 0 outside the WAIT states. blk_valid outside them is ignored and never consumed.
- start while busy is ignored. Latched values are unaffected by input changes during operation.
- Counters are LEN_W wide and count down. There is no wrap: exits are decided on the pre-decrement value == 1.
- Latency with the engine returning round_done after R cycles, no handshake stalls, a AD blocks and m message blocks: IDLE->DONE spans a fixed state sequence. The bench computes it from the state list above.

Test Plan:
- Encrypt, ad_blocks=1, msg_blocks=1, engine done after R rounds -> phase sequence 0,1,2,3,4,5,6,8,9,10,11,0; round_start pulses 3 times with total_rounds 12,6,12; done once; auth_fail=0.
- ad_blocks=0, msg_blocks=3 -> AD states skipped, dom_sep still pulses once, absorb_msg pulses 3 times, MSG_PERM entered exactly 2 times.
- blk_valid held low 5 cycles in AD_WAIT -> blk_ready stays 1, no absorb_ad, no round_start until blk_valid rises.
- Decrypt with tag_match=0 -> auth_fail=1 at done and held; the next start clears it to 0; decrypt with tag_match=1 -> auth_fail=0.
- start pulsed and ad_blocks changed mid-operation; spurious round_done in AD_WAIT -> no state change, original counts used.
- rst asserted in MSG_PERM -> all outputs 0 asynchronously, no done; the next start runs a full sequence correctly.
